// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: walks an address range, reads each codeword through the
// external SEC-DED decoder, writes back corrected single-bit errors and logs doubles.
module ecc_scrub_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [ADDR_W-1:0] END_ADDR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [38:0]       MEM_WDATA,
  input  logic [38:0]       MEM_RDATA,
  input  logic              MEM_ACK,
  output logic [38:0]       DEC_IN,
  input  logic [38:0]       DEC_OUT,
  input  logic              DEC_SGL,
  input  logic              DEC_DBL,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED,
  output logic [CNT_W-1:0]  SGL_CNT,
  output logic [CNT_W-1:0]  DBL_CNT,
  output logic              DBL_SEEN,
  output logic [ADDR_W-1:0] DBL_ADDR
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_WB, S_NEXT, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [38:0]         word_q, word_d;
  logic [38:0]         wr_q, wr_d;
  logic [CNT_W-1:0]    sgl_cnt_q, sgl_cnt_d;
  logic [CNT_W-1:0]    dbl_cnt_q, dbl_cnt_d;
  logic                dbl_seen_q, dbl_seen_d;
  logic [ADDR_W-1:0]   dbl_addr_q, dbl_addr_d;
  logic                aborted_q, aborted_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      word_q     <= '0;
      wr_q       <= '0;
      sgl_cnt_q  <= '0;
      dbl_cnt_q  <= '0;
      dbl_seen_q <= 1'b0;
      dbl_addr_q <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      word_q     <= word_d;
      wr_q       <= wr_d;
      sgl_cnt_q  <= sgl_cnt_d;
      dbl_cnt_q  <= dbl_cnt_d;
      dbl_seen_q <= dbl_seen_d;
      dbl_addr_q <= dbl_addr_d;
      aborted_q  <= aborted_d;
    end
  end

  // A word flagged both single and double is handled as uncorrectable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_RD;
      S_RD:    if (MEM_ACK) state_d = S_CHK;
      S_CHK:   state_d = (DEC_SGL && !DEC_DBL) ? S_WB : S_NEXT;
      S_WB:    if (MEM_ACK) state_d = S_NEXT;
      S_NEXT:  state_d = (ABORT || addr_q == end_q) ? S_FIN : S_RD;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    end_d      = end_q;
    word_d     = word_q;
    wr_d       = wr_q;
    sgl_cnt_d  = sgl_cnt_q;
    dbl_cnt_d  = dbl_cnt_q;
    dbl_seen_d = dbl_seen_q;
    dbl_addr_d = dbl_addr_q;
    aborted_d  = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d     = START_ADDR;
          end_d      = END_ADDR;
          sgl_cnt_d  = '0;
          dbl_cnt_d  = '0;
          dbl_seen_d = 1'b0;
          dbl_addr_d = '0;
          aborted_d  = 1'b0;
        end
      end
      S_RD: if (MEM_ACK) word_d = MEM_RDATA;
      S_CHK: begin
        if (DEC_DBL) begin
          if (dbl_cnt_q != '1) dbl_cnt_d = dbl_cnt_q + CNT_W'(1);
          if (!dbl_seen_q) begin
            dbl_seen_d = 1'b1;
            dbl_addr_d = addr_q;
          end
        end else if (DEC_SGL) begin
          wr_d = DEC_OUT;
          if (sgl_cnt_q != '1) sgl_cnt_d = sgl_cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (ABORT) aborted_d = 1'b1;
        else if (addr_q != end_q) addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Handshake outputs decode from the state register only.
  always_comb begin
    MEM_REQ = (state_q == S_RD) || (state_q == S_WB);
    MEM_WE  = (state_q == S_WB);
    BUSY    = (state_q != S_IDLE);
    DONE    = (state_q == S_FIN);
  end

  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wr_q;
  assign DEC_IN    = word_q;
  assign ABORTED   = aborted_q;
  assign SGL_CNT   = sgl_cnt_q;
  assign DBL_CNT   = dbl_cnt_q;
  assign DBL_SEEN  = dbl_seen_q;
  assign DBL_ADDR  = dbl_addr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scoreboard bench for ecc_scrub_ctrl: memory/decoder models, reference pass model,
// decoupled access and completion monitors.
module tb_ecc_scrub_ctrl;
  localparam int AW = 10;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort;
  logic [AW-1:0] start_addr, end_addr;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [38:0]   mem_wdata, mem_rdata, dec_in, dec_out;
  logic          dec_sgl, dec_dbl, busy, done, aborted, dbl_seen;
  logic [CW-1:0] sgl_cnt, dbl_cnt;
  logic [AW-1:0] dbl_addr;

  logic          s_req, s_we, s_busy, s_done, s_aborted, s_seen;
  logic [AW-1:0] s_addr, s_daddr;
  logic [38:0]   s_wdata, s_decin;
  logic [1:0]    s_sgl, s_dbl;

  ecc_scrub_ctrl #(.ADDR_W(AW), .CNT_W(CW)) u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
    .START_ADDR(start_addr), .END_ADDR(end_addr),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack),
    .DEC_IN(dec_in), .DEC_OUT(dec_out), .DEC_SGL(dec_sgl), .DEC_DBL(dec_dbl),
    .BUSY(busy), .DONE(done), .ABORTED(aborted),
    .SGL_CNT(sgl_cnt), .DBL_CNT(dbl_cnt), .DBL_SEEN(dbl_seen), .DBL_ADDR(dbl_addr)
  );

  // Narrow-counter twin sharing every input, used for saturation checks.
  ecc_scrub_ctrl #(.ADDR_W(AW), .CNT_W(2)) u_sat (
    .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
    .START_ADDR(start_addr), .END_ADDR(end_addr),
    .MEM_REQ(s_req), .MEM_WE(s_we), .MEM_ADDR(s_addr), .MEM_WDATA(s_wdata),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack),
    .DEC_IN(s_decin), .DEC_OUT(dec_out), .DEC_SGL(dec_sgl), .DEC_DBL(dec_dbl),
    .BUSY(s_busy), .DONE(s_done), .ABORTED(s_aborted),
    .SGL_CNT(s_sgl), .DBL_CNT(s_dbl), .DBL_SEEN(s_seen), .DBL_ADDR(s_daddr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SEC-DED code model (odd-weight columns) ----------------
  function automatic logic [6:0] hcol(input int i);
    int n = 0;
    logic [6:0] vv;
    for (int v = 1; v < 128; v++) begin
      vv = 7'(v);
      if ($countones(vv) == 3) begin
        if (n == i) return vv;
        n++;
      end
    end
    return 7'd0;
  endfunction

  function automatic logic [6:0] checks(input logic [31:0] d);
    logic [6:0] c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= hcol(i);
    return c;
  endfunction

  function automatic logic [38:0] encode(input logic [31:0] d);
    return {checks(d), d};
  endfunction

  typedef struct packed {logic [38:0] o; logic s; logic d;} dec_t;

  function automatic dec_t decode(input logic [38:0] c);
    dec_t r;
    logic [6:0] syn;
    bit hit;
    r.o = c; r.s = 1'b0; r.d = 1'b0; hit = 1'b0;
    syn = c[38:32] ^ checks(c[31:0]);
    if (syn != 7'd0) begin
      if ($countones(syn) % 2 == 0) r.d = 1'b1;
      else begin
        for (int j = 0; j < 7; j++)
          if (syn == (7'd1 << j)) begin r.o[32+j] = ~r.o[32+j]; hit = 1'b1; end
        for (int i = 0; i < 32; i++)
          if (syn == hcol(i)) begin r.o[i] = ~r.o[i]; hit = 1'b1; end
        if (hit) r.s = 1'b1; else r.d = 1'b1;
      end
    end
    return r;
  endfunction

  bit   both_mode;
  dec_t dec_r;
  always_comb dec_r = decode(dec_in);
  assign dec_out = dec_r.o;
  assign dec_dbl = dec_r.d;
  assign dec_sgl = dec_r.s || (both_mode && dec_r.d);

  // ---------------- memory contents and reference model ----------------
  logic [38:0] golden [1024];
  logic [38:0] mem    [1024];
  int          nerr   [1024];

  typedef struct {logic we; logic [AW-1:0] addr; logic [38:0] wdata;} acc_t;
  typedef struct {int sgl; int dbl; logic seen; logic [AW-1:0] daddr; logic ab;} st_t;
  acc_t exp_acc[$];
  st_t  exp_st[$];
  st_t  last_st;

  task automatic inject(input logic [AW-1:0] a, input int n);
    int b1, b2;
    b1 = $urandom_range(0, 38);
    b2 = (b1 + $urandom_range(1, 38)) % 39;
    mem[a] = golden[a];
    if (n >= 1) mem[a][b1] = ~mem[a][b1];
    if (n >= 2) mem[a][b2] = ~mem[a][b2];
    nerr[a] = n;
  endtask

  // Expected pass: every word from s up to e (wrapping), stopping early after the aborted word.
  task automatic build_ref(input logic [AW-1:0] s, input logic [AW-1:0] e, input int abort_idx);
    st_t st;
    logic [AW-1:0] a;
    int idx;
    bit fin;
    st = '{0, 0, 1'b0, '0, 1'b0};
    a = s; idx = 0; fin = 1'b0;
    while (!fin) begin
      exp_acc.push_back('{1'b0, a, 39'd0});
      if (nerr[a] == 1) begin
        exp_acc.push_back('{1'b1, a, golden[a]});
        st.sgl++;
        nerr[a] = 0;
      end else if (nerr[a] == 2) begin
        st.dbl++;
        if (!st.seen) begin st.seen = 1'b1; st.daddr = a; end
      end
      if (idx == abort_idx) begin st.ab = 1'b1; fin = 1'b1; end
      else if (a == e) fin = 1'b1;
      else begin a = a + AW'(1); idx++; end
    end
    exp_st.push_back(st);
    last_st = st;
  endtask

  // ---------------- memory responder + access scoreboard ----------------
  bit            block_wr, stall_en, rand_dly;
  logic [AW-1:0] stall_addr;
  int            stall_cyc;

  initial begin
    bit   req_act;
    int   wait_left;
    acc_t cap, e;
    req_act = 1'b0; wait_left = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = 39'({$urandom(), $urandom()});
      if (!rst_n || !mem_req) begin
        mem_ack = 1'b0;
        req_act = 1'b0;
      end else begin
        if (!req_act) begin
          req_act = 1'b1;
          cap = '{mem_we, mem_addr, mem_wdata};
          if (stall_en && !mem_we && mem_addr == stall_addr) wait_left = stall_cyc;
          else if (rand_dly) wait_left = $urandom_range(0, 3);
          else wait_left = 0;
        end else begin
          chk("req_stable", {14'd0, mem_we, mem_addr, mem_wdata}, {14'd0, cap.we, cap.addr, cap.wdata});
        end
        if (wait_left == 0 && !(mem_we && block_wr)) begin
          mem_ack = 1'b1;
          req_act = 1'b0;
          if (!mem_we) mem_rdata = mem[mem_addr];
          else mem[mem_addr] = mem_wdata;
          if (exp_acc.size() == 0) begin
            total++; bad++;
            $display("FAIL acc_unexpected: got we=%0d addr=%0d, required no access", mem_we, mem_addr);
          end else begin
            e = exp_acc.pop_front();
            chk("acc_we", 64'(mem_we), 64'(e.we));
            chk("acc_addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) chk("acc_wdata", 64'(mem_wdata), 64'(e.wdata));
          end
        end else begin
          mem_ack = 1'b0;
          if (wait_left > 0) wait_left--;
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    st_t s;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_st.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got DONE=1, required no pass in flight");
        end else begin
          s = exp_st.pop_front();
          chk("sgl_cnt", 64'(sgl_cnt), 64'(s.sgl));
          chk("dbl_cnt", 64'(dbl_cnt), 64'(s.dbl));
          chk("dbl_seen", 64'(dbl_seen), 64'(s.seen));
          chk("dbl_addr", 64'(dbl_addr), 64'(s.daddr));
          chk("aborted", 64'(aborted), 64'(s.ab));
          chk("busy_in_fin", 64'(busy), 64'd1);
          chk("sat_sgl", 64'(s_sgl), 64'((s.sgl > 3) ? 3 : s.sgl));
          chk("sat_dbl", 64'(s_dbl), 64'((s.dbl > 3) ? 3 : s.dbl));
          chk("acc_left", 64'(exp_acc.size()), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_pass(input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input int abort_idx, input bit spur, output int ncyc);
    logic [AW-1:0] ab_addr;
    bit got;
    build_ref(s, e, abort_idx);
    ab_addr = AW'(s + AW'(abort_idx));
    @(negedge clk);
    start_addr = s; end_addr = e; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_addr = AW'($urandom()); end_addr = AW'($urandom());
    ncyc = 0; got = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      ncyc = k;
      if (spur && k == 2) begin start = 1'b1; start_addr = AW'($urandom()); end
      if (k == 3) start = 1'b0;
      if (abort_idx >= 0 && mem_req && !mem_we && mem_addr == ab_addr) abort = 1'b1;
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL pass_timeout: got no DONE within 3000 cycles, required DONE for %0d..%0d", s, e);
    end
    abort = 1'b0;
    @(negedge clk);
    chk("busy_after_fin", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("sgl_hold", 64'(sgl_cnt), 64'(last_st.sgl));
    chk("dbl_addr_hold", 64'(dbl_addr), 64'(last_st.daddr));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_aborted"}, 64'(aborted), 64'd0);
    chk({tag, "_cnts"}, {32'(sgl_cnt), 32'(dbl_cnt)}, 64'd0);
    chk({tag, "_dbl"}, {63'(dbl_addr), dbl_seen}, 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_decin"}, 64'(dec_in), 64'd0);
  endtask

  initial begin
    int n, len, ab;
    logic [AW-1:0] s, e;
    bit got;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0; end_addr = '0;
    both_mode = 1'b0; block_wr = 1'b0; stall_en = 1'b0; rand_dly = 1'b0;
    stall_addr = '0; stall_cyc = 0;
    for (int a = 0; a < 1024; a++) begin
      golden[a] = encode($urandom());
      mem[a] = golden[a];
      nerr[a] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run_pass(10'd4, 10'd7, -1, 1'b0, n);
    chk("clean_done_cycle", 64'(n), 64'd13);

    mem[5] = golden[5] ^ (39'd1 << 17); nerr[5] = 1;
    run_pass(10'd4, 10'd7, -1, 1'b0, n);

    inject(10'd6, 2); inject(10'd9, 2);
    run_pass(10'd0, 10'd15, -1, 1'b0, n);

    run_pass(10'd1022, 10'd1, -1, 1'b0, n);

    stall_en = 1'b1; stall_addr = 10'd2; stall_cyc = 5;
    run_pass(10'd0, 10'd15, 2, 1'b0, n);
    stall_en = 1'b0;

    both_mode = 1'b1;
    inject(10'd20, 2); inject(10'd21, 1);
    run_pass(10'd18, 10'd22, -1, 1'b0, n);
    both_mode = 1'b0;

    for (int a = 100; a <= 104; a++) inject(AW'(a), 1);
    run_pass(10'd100, 10'd104, -1, 1'b0, n);

    rand_dly = 1'b1;
    for (int p = 0; p < 25; p++) begin
      s = AW'($urandom_range(0, 1023));
      len = $urandom_range(1, 12);
      e = AW'(s + AW'(len - 1));
      for (int i = 0; i < len; i++) begin
        n = $urandom_range(0, 9);
        if (n < 2) inject(AW'(s + AW'(i)), 1);
        else if (n == 2) inject(AW'(s + AW'(i)), 2);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      both_mode = ($urandom_range(0, 1) == 1);
      run_pass(s, e, ab, ($urandom_range(0, 1) == 1), n);
    end
    both_mode = 1'b0;
    rand_dly = 1'b0;

    // Reset while a writeback is waiting for its ACK.
    inject(10'd50, 1);
    block_wr = 1'b1;
    build_ref(10'd50, 10'd50, -1);
    @(negedge clk);
    start_addr = 10'd50; end_addr = 10'd50; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin got = 1'b1; break; end
    end
    chk("wb_reached", 64'(got), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midwb_reset");
    exp_acc.delete();
    exp_st.delete();
    nerr[50] = 1;
    block_wr = 1'b0;
    rst_n = 1'b1;
    run_pass(10'd48, 10'd52, -1, 1'b0, n);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: got no completion by 900000, required finish earlier");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
